// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit definitions for the router input path
package noc_pkg;

    localparam int FLIT_WIDTH = 34;
    localparam int TYPE_W     = 2;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_HEAD_TAIL = 2'b10,
        FLIT_TAIL      = 2'b11
    } flit_type_e;

    // "head" means the flit opens a packet, "tail" means it closes one.
    function automatic logic is_head(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single virtual-channel FIFO with wrap-bit pointers
module vc_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = CNT_W - 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head_data
);

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + CNT_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // Storage is not reset; the consumer gates head_data with empty.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);
    assign count     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - multi-VC router input buffer with round-robin drain
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
    parameter int NUM_VC     = 4,
    parameter int DEPTH      = 4,
    parameter int PKT_HOLD   = 1,
    localparam int VC_W      = $clog2(NUM_VC),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [FLIT_WIDTH-1:0]   fdata_i,
    input  logic [VC_W-1:0]         vc_id_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FLIT_WIDTH-1:0]   fdata_o,
    output logic [VC_W-1:0]         vc_id_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NUM_VC*CNT_W-1:0] ocup_o,
    output logic                    err_o
);

    logic [NUM_VC-1:0]     in_lock;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [NUM_VC-1:0]     wr_en;
    logic [NUM_VC-1:0]     rd_en;
    logic [FLIT_WIDTH-1:0] head_data [NUM_VC];

    flit_type_e            in_type;
    flit_type_e            out_type;
    logic                  legal;
    logic                  hs;

    logic [VC_W-1:0]       rr_ptr_q;
    logic [VC_W-1:0]       rr_sel;
    logic [VC_W-1:0]       sel;
    logic [VC_W-1:0]       sel_q;
    logic [VC_W-1:0]       hold_vc_q;
    logic                  hold_q;
    logic                  stall_q;
    logic                  err_q;

    assign in_type = flit_type_e'(fdata_i[FLIT_WIDTH-1 -: TYPE_W]);

    // A packet opener needs a free VC, a continuation needs an open one.
    assign legal   = is_head(in_type) ? !in_lock[vc_id_i] : in_lock[vc_id_i];
    assign ready_o = !full[vc_id_i] && legal;

    always_comb begin
        wr_en = '0;
        if (valid_i && ready_o) wr_en[vc_id_i] = 1'b1;
    end

    always_comb begin
        rd_en = '0;
        if (hs) rd_en[sel] = 1'b1;
    end

    for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
        vc_fifo #(
            .W     (FLIT_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .arst      (arst),
            .wr_en     (wr_en[k]),
            .wr_data   (fdata_i),
            .rd_en     (rd_en[k]),
            .full      (full[k]),
            .empty     (empty[k]),
            .count     (ocup_o[k*CNT_W +: CNT_W]),
            .head_data (head_data[k])
        );
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            in_lock <= '0;
        end else if (valid_i && ready_o) begin
            if (in_type == FLIT_HEAD)      in_lock[vc_id_i] <= 1'b1;
            else if (in_type == FLIT_TAIL) in_lock[vc_id_i] <= 1'b0;
        end
    end

    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        rr_sel = rr_ptr_q;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_VC;
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                rr_sel = VC_W'(idx);
            end
        end
    end

    // Open packet grant beats a stalled flit, which beats fresh arbitration.
    always_comb begin
        if (hold_q)       sel = hold_vc_q;
        else if (stall_q) sel = sel_q;
        else              sel = rr_sel;
    end

    assign valid_o  = !empty[sel];
    assign fdata_o  = valid_o ? head_data[sel] : '0;
    assign vc_id_o  = sel;
    assign hs       = valid_o && ready_i;
    assign out_type = flit_type_e'(head_data[sel][FLIT_WIDTH-1 -: TYPE_W]);
    assign err_o    = err_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rr_ptr_q  <= '0;
            sel_q     <= '0;
            stall_q   <= 1'b0;
            hold_q    <= 1'b0;
            hold_vc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            stall_q <= valid_o && !ready_i;
            sel_q   <= sel;
            err_q   <= valid_i && !legal;
            if (hs) begin
                rr_ptr_q <= (sel == VC_W'(NUM_VC - 1)) ? '0 : sel + VC_W'(1);
                if (PKT_HOLD != 0) begin
                    if (out_type == FLIT_HEAD) begin
                        hold_q    <= 1'b1;
                        hold_vc_q <= sel;
                    end else if (out_type == FLIT_TAIL) begin
                        hold_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - directed self-checking bench for vc_input_buffer
module tb_vc_input_buffer;

    localparam int FW = 34;
    localparam int VW = 2;
    localparam int CW = 3;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic          clk = 1'b0;
    logic          arst = 1'b1;

    logic [FW-1:0] a_fdata_i = '0, a_fdata_o;
    logic [VW-1:0] a_vc_id_i = '0, a_vc_id_o;
    logic          a_valid_i = 1'b0, a_ready_o, a_valid_o, a_ready_i = 1'b0, a_err_o;
    logic [4*CW-1:0] a_ocup_o;

    logic [FW-1:0] b_fdata_i = '0, b_fdata_o;
    logic [VW-1:0] b_vc_id_i = '0, b_vc_id_o;
    logic          b_valid_i = 1'b0, b_ready_o, b_valid_o, b_ready_i = 1'b0, b_err_o;
    logic [4*CW-1:0] b_ocup_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vc_input_buffer #(.FLIT_WIDTH(FW), .NUM_VC(4), .DEPTH(4), .PKT_HOLD(1)) dut_a (
        .clk(clk), .arst(arst),
        .fdata_i(a_fdata_i), .vc_id_i(a_vc_id_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .fdata_o(a_fdata_o), .vc_id_o(a_vc_id_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .ocup_o(a_ocup_o), .err_o(a_err_o)
    );

    vc_input_buffer #(.FLIT_WIDTH(FW), .NUM_VC(4), .DEPTH(4), .PKT_HOLD(0)) dut_b (
        .clk(clk), .arst(arst),
        .fdata_i(b_fdata_i), .vc_id_i(b_vc_id_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .fdata_o(b_fdata_o), .vc_id_o(b_vc_id_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .ocup_o(b_ocup_o), .err_o(b_err_o)
    );

    function automatic logic [FW-1:0] flit(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    function automatic logic [CW-1:0] occ(input logic [4*CW-1:0] v, input int k);
        return v[k*CW +: CW];
    endfunction

    task automatic test_reset();
        a_fdata_i = flit(T_HEAD, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid_o); end
        checks++; if (a_fdata_o !== '0) begin failures++; $display("FAIL reset_fdata got=%h exp=0", a_fdata_o); end
        checks++; if (a_vc_id_o !== '0) begin failures++; $display("FAIL reset_vc_id got=%0d exp=0", a_vc_id_o); end
        checks++; if (a_ocup_o !== '0) begin failures++; $display("FAIL reset_ocup got=%h exp=0", a_ocup_o); end
        checks++; if (a_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", a_err_o); end
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready_o); end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        a_ready_i = 1'b1; a_vc_id_i = 2'd0; a_fdata_i = flit(T_HEAD, 32'h1234); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", a_ready_o); end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", a_valid_o); end
        checks++; if (a_vc_id_o !== 2'd0) begin failures++; $display("FAIL single_vc got=%0d exp=0", a_vc_id_o); end
        checks++; if (a_fdata_o !== flit(T_HEAD, 32'h1234)) begin failures++; $display("FAIL single_data got=%h exp=%h", a_fdata_o, flit(T_HEAD, 32'h1234)); end
        checks++; if (occ(a_ocup_o, 0) !== 3'd1) begin failures++; $display("FAIL single_ocup1 got=%0d exp=1", occ(a_ocup_o, 0)); end
        @(negedge clk); #1;
        checks++; if (occ(a_ocup_o, 0) !== 3'd0) begin failures++; $display("FAIL single_ocup0 got=%0d exp=0", occ(a_ocup_o, 0)); end
        checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", a_valid_o); end
        a_fdata_i = flit(T_TAIL, 32'h1235); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL single_tail_ready got=%b exp=1", a_ready_o); end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_fdata_o !== flit(T_TAIL, 32'h1235)) begin failures++; $display("FAIL single_tail_data got=%h exp=%h", a_fdata_o, flit(T_TAIL, 32'h1235)); end
        @(negedge clk); #1;
        checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", a_valid_o); end
    endtask

    logic [FW-1:0] pat [4];

    task automatic test_full();
        pat[0] = flit(T_HEAD, 32'h20); pat[1] = flit(T_BODY, 32'h21);
        pat[2] = flit(T_BODY, 32'h22); pat[3] = flit(T_TAIL, 32'h23);
        a_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_vc_id_i = 2'd2; a_fdata_i = pat[i]; a_valid_i = 1'b1;
            #1;
            checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL full_wr%0d_ready got=%b exp=1", i, a_ready_o); end
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (occ(a_ocup_o, 2) !== 3'd4) begin failures++; $display("FAIL full_ocup got=%0d exp=4", occ(a_ocup_o, 2)); end
        a_fdata_i = flit(T_HEAD, 32'h99); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL full_5th_ready got=%b exp=0", a_ready_o); end
        a_vc_id_i = 2'd1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL full_vc1_ready got=%b exp=1", a_ready_o); end
        a_valid_i = 1'b0;
        checks++; if (a_vc_id_o !== 2'd2 || a_fdata_o !== pat[0]) begin failures++; $display("FAIL full_out got=%0d/%h exp=2/%h", a_vc_id_o, a_fdata_o, pat[0]); end
    endtask

    task automatic test_full_rw();
        @(negedge clk);
        a_ready_i = 1'b1; a_vc_id_i = 2'd2; a_fdata_i = flit(T_HEAD, 32'h24); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL rw_ready got=%b exp=0", a_ready_o); end
        checks++; if (a_fdata_o !== pat[0]) begin failures++; $display("FAIL rw_head got=%h exp=%h", a_fdata_o, pat[0]); end
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            a_valid_i = 1'b0;
            #1;
            checks++; if (occ(a_ocup_o, 2) !== 3'(4 - j)) begin failures++; $display("FAIL rw_ocup%0d got=%0d exp=%0d", j, occ(a_ocup_o, 2), 4 - j); end
            checks++; if (a_fdata_o !== pat[j] || a_vc_id_o !== 2'd2) begin failures++; $display("FAIL rw_out%0d got=%0d/%h exp=2/%h", j, a_vc_id_o, a_fdata_o, pat[j]); end
        end
        @(negedge clk); #1;
        checks++; if (a_valid_o !== 1'b0 || occ(a_ocup_o, 2) !== 3'd0) begin failures++; $display("FAIL rw_empty got=%b/%0d exp=0/0", a_valid_o, occ(a_ocup_o, 2)); end
        checks++; if (a_err_o !== 1'b0) begin failures++; $display("FAIL rw_err got=%b exp=0", a_err_o); end
    endtask

    task automatic test_illegal();
        a_ready_i = 1'b0;
        @(negedge clk);
        a_vc_id_i = 2'd3; a_fdata_i = flit(T_BODY, 32'h30); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL ill_body_ready got=%b exp=0", a_ready_o); end
        @(negedge clk); #1;
        checks++; if (a_err_o !== 1'b1) begin failures++; $display("FAIL ill_err1 got=%b exp=1", a_err_o); end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_err_o !== 1'b1) begin failures++; $display("FAIL ill_err2 got=%b exp=1", a_err_o); end
        @(negedge clk); #1;
        checks++; if (a_err_o !== 1'b0) begin failures++; $display("FAIL ill_err_clr got=%b exp=0", a_err_o); end
        checks++; if (occ(a_ocup_o, 3) !== 3'd0) begin failures++; $display("FAIL ill_ocup0 got=%0d exp=0", occ(a_ocup_o, 3)); end
        a_fdata_i = flit(T_HEAD, 32'h31); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL ill_head_ready got=%b exp=1", a_ready_o); end
        @(negedge clk);
        a_fdata_i = flit(T_HEAD, 32'h32);
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL ill_relock_ready got=%b exp=0", a_ready_o); end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_err_o !== 1'b1) begin failures++; $display("FAIL ill_relock_err got=%b exp=1", a_err_o); end
        checks++; if (occ(a_ocup_o, 3) !== 3'd1) begin failures++; $display("FAIL ill_ocup1 got=%0d exp=1", occ(a_ocup_o, 3)); end
        @(negedge clk); #1;
        checks++; if (a_err_o !== 1'b0) begin failures++; $display("FAIL ill_err_clr2 got=%b exp=0", a_err_o); end
        a_fdata_i = flit(T_TAIL, 32'h33); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL ill_tail_ready got=%b exp=1", a_ready_o); end
        @(negedge clk);
        a_valid_i = 1'b0; a_ready_i = 1'b1;
        #1;
        checks++; if (a_fdata_o !== flit(T_HEAD, 32'h31)) begin failures++; $display("FAIL ill_out0 got=%h exp=%h", a_fdata_o, flit(T_HEAD, 32'h31)); end
        @(negedge clk); #1;
        checks++; if (a_fdata_o !== flit(T_TAIL, 32'h33)) begin failures++; $display("FAIL ill_out1 got=%h exp=%h", a_fdata_o, flit(T_TAIL, 32'h33)); end
        @(negedge clk); #1;
        checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL ill_idle got=%b exp=0", a_valid_o); end
    endtask

    logic [VW-1:0] ld_vc [4];
    logic [1:0]    ld_ty [4];

    task automatic test_hold_order();
        ld_vc[0] = 2'd0; ld_vc[1] = 2'd1; ld_vc[2] = 2'd0; ld_vc[3] = 2'd1;
        ld_ty[0] = T_HEAD; ld_ty[1] = T_HEAD; ld_ty[2] = T_TAIL; ld_ty[3] = T_TAIL;
        a_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_vc_id_i = ld_vc[i]; a_fdata_i = flit(ld_ty[i], 32'h40 + 32'(i)); a_valid_i = 1'b1;
            #1;
            checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL hold_wr%0d_ready got=%b exp=1", i, a_ready_o); end
        end
        @(negedge clk);
        a_valid_i = 1'b0; a_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [VW-1:0] ev;
            logic [31:0]   ep;
            ev = (i < 2) ? 2'd0 : 2'd1;
            ep = (i == 0) ? 32'h40 : (i == 1) ? 32'h42 : (i == 2) ? 32'h41 : 32'h43;
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (a_vc_id_o !== ev || a_fdata_o[31:0] !== ep) begin failures++; $display("FAIL hold_out%0d got=%0d/%h exp=%0d/%h", i, a_vc_id_o, a_fdata_o[31:0], ev, ep); end
        end
        @(negedge clk); #1;
        checks++; if (a_valid_o !== 1'b0) begin failures++; $display("FAIL hold_idle got=%b exp=0", a_valid_o); end
    endtask

    task automatic test_interleave();
        b_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_vc_id_i = ld_vc[i]; b_fdata_i = flit(ld_ty[i], 32'h40 + 32'(i)); b_valid_i = 1'b1;
            #1;
            checks++; if (b_ready_o !== 1'b1) begin failures++; $display("FAIL ilv_wr%0d_ready got=%b exp=1", i, b_ready_o); end
        end
        @(negedge clk);
        b_valid_i = 1'b0; b_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [VW-1:0] ev;
            ev = (i % 2 == 0) ? 2'd0 : 2'd1;
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (b_vc_id_o !== ev || b_fdata_o[31:0] !== 32'h40 + 32'(i)) begin failures++; $display("FAIL ilv_out%0d got=%0d/%h exp=%0d/%h", i, b_vc_id_o, b_fdata_o[31:0], ev, 32'h40 + 32'(i)); end
        end
        @(negedge clk); #1;
        checks++; if (b_valid_o !== 1'b0) begin failures++; $display("FAIL ilv_idle got=%b exp=0", b_valid_o); end
    endtask

    task automatic test_stall_reset();
        a_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_vc_id_i = 2'd1; a_fdata_i = flit((i == 0) ? T_HEAD : (i == 1) ? T_BODY : T_TAIL, 32'h50 + 32'(i));
            a_valid_i = 1'b1;
        end
        @(negedge clk);
        a_valid_i = 1'b0; a_ready_i = 1'b1;
        #1;
        checks++; if (a_fdata_o !== flit(T_HEAD, 32'h50)) begin failures++; $display("FAIL stall_head got=%h exp=%h", a_fdata_o, flit(T_HEAD, 32'h50)); end
        @(negedge clk);
        a_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (a_valid_o !== 1'b1 || a_vc_id_o !== 2'd1 || a_fdata_o !== flit(T_BODY, 32'h51)) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%0d/%h exp=1/1/%h", i, a_valid_o, a_vc_id_o, a_fdata_o, flit(T_BODY, 32'h51));
            end
        end
        #2 arst = 1'b1;
        #1;
        checks++; if (a_valid_o !== 1'b0 || a_fdata_o !== '0 || a_vc_id_o !== '0) begin failures++; $display("FAIL arst_out got=%b/%h/%0d exp=0/0/0", a_valid_o, a_fdata_o, a_vc_id_o); end
        checks++; if (a_ocup_o !== '0 || a_err_o !== 1'b0) begin failures++; $display("FAIL arst_ocup got=%h/%b exp=0/0", a_ocup_o, a_err_o); end
        @(negedge clk);
        arst = 1'b0;
        a_vc_id_i = 2'd1; a_fdata_i = flit(T_BODY, 32'h60); a_valid_i = 1'b1;
        #1;
        checks++; if (a_ready_o !== 1'b0) begin failures++; $display("FAIL arst_body_ready got=%b exp=0", a_ready_o); end
        a_fdata_i = flit(T_HEAD, 32'h61);
        #1;
        checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL arst_head_ready got=%b exp=1", a_ready_o); end
        a_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_rw();
        test_illegal();
        test_hold_order();
        test_interleave();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
